// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS pipeline hazard/next-PC control
package mips_pkg;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

endpackage

// File: rtl/forwarding_select.sv
// rtl/forwarding_select.sv - ALU operand forwarding select for one EX source register
import mips_pkg::*;

module forwarding_select (
    input  logic [4:0] src,
    input  logic [4:0] exmem_dst,
    input  logic       exmem_reg_write,
    input  logic [4:0] memwb_dst,
    input  logic       memwb_reg_write,
    output logic [1:0] sel
);

    // The younger EX/MEM result shadows an older MEM/WB write to the same register.
    always_comb begin
        sel = FWD_REG;
        if (exmem_reg_write && exmem_dst != REG_ZERO && exmem_dst == src) begin
            sel = FWD_EX;
        end else if (memwb_reg_write && memwb_dst != REG_ZERO && memwb_dst == src) begin
            sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - hazard detection, stall sequencing, flush and next-PC selects
import mips_pkg::*;

module hazard_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             id_jump,
    input  logic             id_jr,
    input  logic [4:0]       idex_rs,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       idex_dst,
    input  logic             idex_reg_write,
    input  logic             idex_mem_read,
    input  logic [4:0]       exmem_dst,
    input  logic             exmem_reg_write,
    input  logic [4:0]       memwb_dst,
    input  logic             memwb_reg_write,
    input  logic             ex_branch_taken,
    input  logic             perf_clr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ctrl_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             branch_sel,
    output logic             jump_sel,
    output logic             jr_sel,
    output logic [CNT_W-1:0] stall_count
);

    state_t     state;
    logic [1:0] rem;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic       load_use;
    logic       jr_ex;
    logic       jr_mem;
    logic [1:0] need;
    logic       stall;

    forwarding_select u_fwd_a (
        .src             (idex_rs),
        .exmem_dst       (exmem_dst),
        .exmem_reg_write (exmem_reg_write),
        .memwb_dst       (memwb_dst),
        .memwb_reg_write (memwb_reg_write),
        .sel             (fwd_a_raw)
    );

    forwarding_select u_fwd_b (
        .src             (idex_rt),
        .exmem_dst       (exmem_dst),
        .exmem_reg_write (exmem_reg_write),
        .memwb_dst       (memwb_dst),
        .memwb_reg_write (memwb_reg_write),
        .sel             (fwd_b_raw)
    );

    // A WB-stage producer is never a jr hazard: the register file writes before it reads.
    always_comb begin
        load_use = idex_mem_read && idex_dst != REG_ZERO &&
                   (idex_dst == ifid_rs || (ifid_uses_rt && idex_dst == ifid_rt));
        jr_ex    = id_jr && ifid_rs != REG_ZERO && idex_reg_write && idex_dst == ifid_rs;
        jr_mem   = id_jr && ifid_rs != REG_ZERO && exmem_reg_write && exmem_dst == ifid_rs;
        need     = 2'd0;
        if (jr_ex) begin
            need = 2'd2;
        end else if (load_use || jr_mem) begin
            need = 2'd1;
        end
    end

    assign stall = rst_n && !ex_branch_taken &&
                   (state == ST_STALL || (state == ST_RUN && need != 2'd0));

    always_comb begin
        fwd_a       = FWD_REG;
        fwd_b       = FWD_REG;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ctrl_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        branch_sel  = 1'b0;
        jump_sel    = 1'b0;
        jr_sel      = 1'b0;
        if (rst_n) begin
            fwd_a = fwd_a_raw;
            fwd_b = fwd_b_raw;
            if (ex_branch_taken) begin
                branch_sel = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                ctrl_bubble = 1'b1;
            end else if (id_jump) begin
                jump_sel   = 1'b1;
                ifid_flush = 1'b1;
            end else if (id_jr) begin
                jr_sel     = 1'b1;
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            rem         <= 2'd0;
            stall_count <= '0;
        end else begin
            if (perf_clr) begin
                stall_count <= '0;
            end else if (stall && stall_count != {CNT_W{1'b1}}) begin
                stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if (ex_branch_taken) begin
                state <= ST_RUN;
                rem   <= 2'd0;
            end else if (state == ST_STALL) begin
                rem <= rem - 2'd1;
                if (rem <= 2'd1) begin
                    state <= ST_RUN;
                end
            end else if (need == 2'd2) begin
                state <= ST_STALL;
                rem   <= 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed self-checking bench for hazard_sequencer
module tb_hazard_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_dst, exmem_dst, memwb_dst;
    logic        ifid_uses_rt, id_jump, id_jr, idex_reg_write, idex_mem_read;
    logic        exmem_reg_write, memwb_reg_write, ex_branch_taken, perf_clr;
    logic [1:0]  fwd_a, fwd_b;
    logic        pc_write, ifid_write, ctrl_bubble, ifid_flush, idex_flush;
    logic        branch_sel, jump_sel, jr_sel;
    logic [15:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(.CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .ifid_uses_rt    (ifid_uses_rt),
        .id_jump         (id_jump),
        .id_jr           (id_jr),
        .idex_rs         (idex_rs),
        .idex_rt         (idex_rt),
        .idex_dst        (idex_dst),
        .idex_reg_write  (idex_reg_write),
        .idex_mem_read   (idex_mem_read),
        .exmem_dst       (exmem_dst),
        .exmem_reg_write (exmem_reg_write),
        .memwb_dst       (memwb_dst),
        .memwb_reg_write (memwb_reg_write),
        .ex_branch_taken (ex_branch_taken),
        .perf_clr        (perf_clr),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ctrl_bubble     (ctrl_bubble),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .branch_sel      (branch_sel),
        .jump_sel        (jump_sel),
        .jr_sel          (jr_sel),
        .stall_count     (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0; id_jump = 1'b0; id_jr = 1'b0;
        idex_rs = 5'd0; idex_rt = 5'd0; idex_dst = 5'd0;
        idex_reg_write = 1'b0; idex_mem_read = 1'b0;
        exmem_dst = 5'd0; exmem_reg_write = 1'b0;
        memwb_dst = 5'd0; memwb_reg_write = 1'b0;
        ex_branch_taken = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with forwarding-matching inputs: all selects must stay at 0.
        rst_n = 1'b0;
        idle();
        exmem_reg_write = 1'b1; exmem_dst = 5'd8; idex_rs = 5'd8;
        idex_mem_read = 1'b1; idex_dst = 5'd8; ifid_rs = 5'd8;
        tick();
        chk("rst_pc_write",    32'(pc_write),    32'd1);
        chk("rst_ifid_write",  32'(ifid_write),  32'd1);
        chk("rst_bubble",      32'(ctrl_bubble), 32'd0);
        chk("rst_fwd_a",       32'(fwd_a),       32'd0);
        chk("rst_stall_count", 32'(stall_count), 32'd0);

        // Forwarding priority and $0 suppression
        rst_n = 1'b1;
        idle();
        exmem_reg_write = 1'b1; exmem_dst = 5'd8;
        memwb_reg_write = 1'b1; memwb_dst = 5'd8;
        idex_rs = 5'd8; idex_rt = 5'd8;
        #1;
        chk("fwd_a_ex_prio", 32'(fwd_a), 32'd1);
        chk("fwd_b_ex_prio", 32'(fwd_b), 32'd1);
        exmem_reg_write = 1'b0;
        #1;
        chk("fwd_a_mem", 32'(fwd_a), 32'd2);
        idex_rt = 5'd7;
        #1;
        chk("fwd_b_nomatch", 32'(fwd_b), 32'd0);
        exmem_reg_write = 1'b1; exmem_dst = 5'd0; memwb_dst = 5'd0; idex_rs = 5'd0;
        #1;
        chk("fwd_a_zero", 32'(fwd_a), 32'd0);
        tick();

        // lw $9 in EX, add using $9 (rs) in ID: one bubble
        idle();
        idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_dst = 5'd9; ifid_rs = 5'd9;
        #1;
        chk("lu_pc_write",   32'(pc_write),   32'd0);
        chk("lu_ifid_write", 32'(ifid_write), 32'd0);
        chk("lu_bubble",     32'(ctrl_bubble), 32'd1);
        tick();
        chk("lu_count", 32'(stall_count), 32'd1);
        idle();
        #1;
        chk("lu_resume_pc_write", 32'(pc_write),    32'd1);
        chk("lu_resume_bubble",   32'(ctrl_bubble), 32'd0);
        tick();
        chk("lu_resume_count", 32'(stall_count), 32'd1);

        // rt match ignored unless the ID instruction reads rt
        idex_mem_read = 1'b1; idex_dst = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9;
        #1;
        chk("lu_rt_unused", 32'(pc_write), 32'd1);
        ifid_uses_rt = 1'b1;
        #1;
        chk("lu_rt_used", 32'(pc_write), 32'd0);
        tick();
        chk("lu_rt_count", 32'(stall_count), 32'd2);

        // addi $31 in EX, jr $31 in ID: two bubbles, then jr taken
        idle();
        id_jr = 1'b1; ifid_rs = 5'd31; idex_reg_write = 1'b1; idex_dst = 5'd31;
        #1;
        chk("jrex_c1_pc_write", 32'(pc_write), 32'd0);
        chk("jrex_c1_jr_sel",   32'(jr_sel),   32'd0);
        tick();
        idex_reg_write = 1'b0; idex_dst = 5'd0; exmem_reg_write = 1'b1; exmem_dst = 5'd31;
        #1;
        chk("jrex_c2_pc_write", 32'(pc_write),    32'd0);
        chk("jrex_c2_bubble",   32'(ctrl_bubble), 32'd1);
        tick();
        exmem_reg_write = 1'b0; exmem_dst = 5'd0; memwb_reg_write = 1'b1; memwb_dst = 5'd31;
        #1;
        chk("jrex_c3_pc_write",   32'(pc_write),   32'd1);
        chk("jrex_c3_jr_sel",     32'(jr_sel),     32'd1);
        chk("jrex_c3_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("jrex_count",         32'(stall_count), 32'd4);
        tick();

        // jr behind a MEM producer: one bubble
        idle();
        id_jr = 1'b1; ifid_rs = 5'd31; exmem_reg_write = 1'b1; exmem_dst = 5'd31;
        #1;
        chk("jrmem_c1_pc_write", 32'(pc_write), 32'd0);
        tick();
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b1; memwb_dst = 5'd31;
        #1;
        chk("jrmem_c2_jr_sel", 32'(jr_sel), 32'd1);
        chk("jrmem_count",     32'(stall_count), 32'd5);
        tick();

        // j in ID
        idle();
        id_jump = 1'b1;
        #1;
        chk("j_jump_sel",   32'(jump_sel),   32'd1);
        chk("j_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("j_idex_flush", 32'(idex_flush), 32'd0);
        chk("j_pc_write",   32'(pc_write),   32'd1);
        tick();

        // Taken branch beats a simultaneous load-use
        idle();
        idex_mem_read = 1'b1; idex_dst = 5'd9; ifid_rs = 5'd9; ex_branch_taken = 1'b1;
        #1;
        chk("br_branch_sel", 32'(branch_sel),  32'd1);
        chk("br_ifid_flush", 32'(ifid_flush),  32'd1);
        chk("br_idex_flush", 32'(idex_flush),  32'd1);
        chk("br_pc_write",   32'(pc_write),    32'd1);
        chk("br_bubble",     32'(ctrl_bubble), 32'd0);
        tick();
        chk("br_count", 32'(stall_count), 32'd5);

        // Reset during STALL aborts the stall
        idle();
        id_jr = 1'b1; ifid_rs = 5'd31; idex_reg_write = 1'b1; idex_dst = 5'd31;
        tick();
        idle();
        #1;
        chk("stall_uncond_pc_write", 32'(pc_write), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_in_stall_pc_write", 32'(pc_write), 32'd1);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_pc_write", 32'(pc_write),    32'd1);
        chk("post_rst_count",    32'(stall_count), 32'd0);
        tick();
        chk("post_rst_run_count", 32'(stall_count), 32'd0);

        // Saturation at 0xFFFF, then perf_clr beats a stall
        idle();
        idex_mem_read = 1'b1; idex_dst = 5'd9; ifid_rs = 5'd9;
        repeat (65535) tick();
        chk("sat_reach", 32'(stall_count), 32'h0000_FFFF);
        tick();
        chk("sat_hold", 32'(stall_count), 32'h0000_FFFF);
        perf_clr = 1'b1;
        tick();
        chk("clr_wins", 32'(stall_count), 32'd0);
        perf_clr = 1'b0;
        tick();
        chk("count_after_clr", 32'(stall_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard and next-PC controller for the 5-stage MIPS core; it drives every select line of the datapath multiplexers: ALU forwarding A/B, the stall bubble mux, and the branch/jump/jr PC mux chain. It detects load-use and jr register hazards in ID and freezes PC and IF/ID for a latched, counted number of cycles. It also flushes younger stages on taken branches and jumps, and keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- CNT_W, 16, width of stall performance counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- ifid_rs, ifid_rt  in  5 each  source registers of instruction in ID
- ifid_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- id_jump  in  1  j/jal decoded in ID
- id_jr  in  1  jr decoded in ID
- idex_rs, idex_rt  in  5 each  sources of instruction in EX
- idex_dst  in  5  destination of EX instruction
- idex_reg_write, idex_mem_read  in  1 each  EX instruction control
- exmem_dst  in  5;  exmem_reg_write  in  1  MEM-stage destination and write enable
- memwb_dst  in  5;  memwb_reg_write  in  1  WB-stage destination and write enable
- ex_branch_taken  in  1  branch resolved taken in EX
- perf_clr  in  1  clear stall counter
- fwd_a, fwd_b  out  2 each  ALU source selects: 0 register file, 1 EX/MEM, 2 MEM/WB
- pc_write, ifid_write  out  1 each  pipeline register enables
- ctrl_bubble  out  1  1 = stall mux drives zeros into ID/EX control
- ifid_flush, idex_flush  out  1 each  synchronous clear of that pipeline register
- branch_sel, jump_sel, jr_sel  out  1 each  selects of the three cascaded PC muxes
- stall_count  out  CNT_W  stall cycles since reset/clear

## Operation
- Forwarding is combinational and computed identically for A (idex_rs) and B (idex_rt).
- Select 1 if exmem_reg_write, exmem_dst≠0 and exmem_dst matches the source.
- Else select 2 if memwb_reg_write, memwb_dst≠0 and memwb_dst matches.
- Else select 0. EX/MEM has priority over MEM/WB.
- Hazard detection applies in RUN only.
- Load-use: idex_mem_read, idex_dst≠0, and idex_dst equals ifid_rs, or equals ifid_rt when ifid_uses_rt. Required stall N=1.
- jr hazard: id_jr and ifid_rs≠0.
  - idex_reg_write with idex_dst==ifid_rs gives N=2.
  - Else exmem_reg_write with exmem_dst==ifid_rs gives N=1.
  - The register file is write-first, so a WB producer needs no stall.
- If both hazards are true, take the larger N.
- FSM states RUN and STALL; down-counter rem (2 bits).
  - RUN, no hazard: normal flow.
  - RUN, hazard with N=1: stall this cycle, stay RUN.
  - RUN, hazard with N=2: stall this cycle, go to STALL with rem=1.
  - STALL: stall unconditionally, with no re-detection. Decrement rem; at rem==1, next state is RUN.
- Stall cycle outputs: pc_write=0, ifid_write=0, ctrl_bubble=1, jr_sel=0, jump_sel=0.
- Priority: ex_branch_taken beats everything.
  - Assert branch_sel, ifid_flush and idex_flush; do not stall.
  - Force the next state to RUN and clear rem. This applies in STALL as well, as a defensive rule.
- Jump in ID with no branch taken: jump_sel=1 (j/jal) or jr_sel=1 (jr, when not stalled), and ifid_flush=1.
- stall_count increments on every stall cycle and saturates at all-ones. perf_clr clears it and wins over increment.

## Timing
- Forwarding, stall, flush and PC selects are Mealy outputs, valid in the same cycle as their inputs.
- State, rem and stall_count update on the rising clk edge.
- Reset (rst_n=0 at an edge):
  - state RUN, rem 0, stall_count 0.
  - Outputs while held in reset: pc_write=1, ifid_write=1, all others 0.
- Reset during STALL aborts the stall; the next cycle is RUN.
- Load-use costs exactly 1 bubble. jr behind an EX producer costs exactly 2 bubbles; behind a MEM producer, 1.

## Structure
- Shared package mips_pkg holds:
  - FWD_REG=0, FWD_EX=1, FWD_MEM=2
  - state encodings ST_RUN, ST_STALL
  - REG_ZERO=5'd0
- One sub-module: forwarding_select (combinational), instantiated twice for A and B.

## Test plan
- EX/MEM writes $8, MEM/WB writes $8, idex_rs=8 -> fwd_a=1. Same case with exmem_reg_write=0 -> fwd_a=2. Source $0 -> fwd_a=0.
- lw $9 in EX, add using $9 in ID -> one cycle with pc_write=0, ctrl_bubble=1, stall_count=1, then normal flow.
- addi $31 in EX, jr $31 in ID -> stalls exactly 2 cycles (STALL entered), then jr_sel=1 and ifid_flush=1; stall_count=2.
- Load-use hazard and ex_branch_taken in the same cycle -> no stall; branch_sel=1, ifid_flush=1, idex_flush=1, stall_count unchanged.
- rst_n low during STALL -> next cycle RUN, stall_count=0, pc_write=1.
- Force 65535 stall cycles, then one more -> stall_count holds 0xFFFF. perf_clr together with a stall -> stall_count=0.
